tl_tx_pkt_fifo: RTL and testbench

- Store-and-forward TLP buffer, one instance per traffic class (posted, non-posted, completion).
- Sits directly upstream of the TX arbiter and drives its per-class pkt_*_i / valid / ready inputs.
- Presents a head-of-queue beat only once the complete packet (through eop) is stored, so the arbiter never stalls mid-packet on an underrun.
- Detects and discards packets too large for the buffer instead of deadlocking.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tl_pf_ram.sv | 25 ++
 rtl/tl_tx_pkt_fifo.sv | 131 +++++++++++++
 tb/tb_tl_tx_pkt_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared TL stream beat type and packet FIFO definitions
package tl_pkg;

    localparam int TL_DATA_W           = 32;
    localparam int TL_PF_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic [TL_DATA_W-1:0] data;
        logic                 sop;
        logic                 eop;
    } tl_stream_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_IN_PKT,
        PF_DROP
    } tl_pf_wr_state_e;

endpackage

// File: rtl/tl_pf_ram.sv
// tl_pf_ram: DEPTH x tl_stream_t storage, registered write, asynchronous read
module tl_pf_ram
    import tl_pkg::*;
#(
    parameter int DEPTH = TL_PF_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  tl_stream_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output tl_stream_t    o_rdata
);

    tl_stream_t r_mem [DEPTH];

    // store one beat per accepted write; contents need no reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_tx_pkt_fifo.sv
// tl_tx_pkt_fifo: store-and-forward TLP buffer; optional stats via TL_TX_PKT_FIFO_STATS_EN
module tl_tx_pkt_fifo
    import tl_pkg::*;
#(
    parameter int DEPTH = TL_PF_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  tl_stream_t       wr_pkt_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output tl_stream_t       rd_pkt_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] occupancy_o,
`ifdef TL_TX_PKT_FIFO_STATS_EN
    output logic [CNT_W-1:0] hwm_o,
    output logic [15:0]      drop_cnt_o,
`endif
    output logic             err_oversize_o,
    output logic             err_framing_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_start_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_pkt_cnt;
    tl_pf_wr_state_e  r_state;
    logic             r_err_ov;
    logic             r_err_fr;

    logic             w_full;
    logic             w_wr;
    logic             w_store;
    logic             w_pop;
    logic             w_rollback;
    logic             w_start;
    logic             w_frame_err;
    logic [AW-1:0]    w_keep;
    tl_stream_t       w_head;

    assign w_full      = r_occ == CNT_W'(DEPTH);
    assign wr_ready_o  = !w_full || (r_state == PF_DROP);
    assign w_wr        = wr_valid_i && wr_ready_o;
    assign w_store     = w_wr && (r_state != PF_DROP);
    assign rd_valid_o  = r_pkt_cnt != '0;
    assign w_pop       = rd_valid_o && rd_ready_i;
    // a full buffer holding no complete packet can never drain: the open packet must go
    assign w_rollback  = (r_state == PF_IN_PKT) && w_full && (r_pkt_cnt == '0);
    // a stored beat opens a packet in IDLE, or when it carries sop inside a packet
    assign w_start     = w_store && ((r_state == PF_IDLE) || wr_pkt_i.sop);
    assign w_frame_err = w_store && ((r_state == PF_IDLE) ? !wr_pkt_i.sop : wr_pkt_i.sop);
    assign w_keep      = r_start_ptr - r_rd_ptr;

    assign rd_pkt_o       = (r_occ == '0) ? '0 : w_head;
    assign pkt_cnt_o      = r_pkt_cnt;
    assign occupancy_o    = r_occ;
    assign err_oversize_o = r_err_ov;
    assign err_framing_o  = r_err_fr;

    tl_pf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_pkt_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // pointers, beat occupancy and complete-packet count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_rollback) begin
                r_wr_ptr <= r_start_ptr;
                r_occ    <= {1'b0, w_keep};
            end else begin
                if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
                r_occ <= r_occ + CNT_W'(w_store) - CNT_W'(w_pop);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(w_store && wr_pkt_i.eop) - CNT_W'(w_pop && w_head.eop);
        end
    end

    // write-side packet framing FSM with sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PF_IDLE;
            r_start_ptr <= '0;
            r_err_ov    <= 1'b0;
            r_err_fr    <= 1'b0;
        end else if (w_rollback) begin
            r_state  <= PF_DROP;
            r_err_ov <= 1'b1;
        end else if (w_wr) begin
            if (w_start) r_start_ptr <= r_wr_ptr;
            if (w_frame_err) r_err_fr <= 1'b1;
            r_state <= wr_pkt_i.eop ? PF_IDLE : ((r_state == PF_DROP) ? PF_DROP : PF_IN_PKT);
        end
    end

`ifdef TL_TX_PKT_FIFO_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic [15:0]      r_drop_cnt;

    // peak occupancy and saturating oversize-drop count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_occ > r_hwm) r_hwm <= r_occ;
            if (w_rollback && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign hwm_o      = r_hwm;
    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tl_tx_pkt_fifo.sv
// tb_tl_tx_pkt_fifo: scoreboard bench with a queue-level reference model
module tb_tl_tx_pkt_fifo;
    import tl_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    tl_stream_t       wr_pkt_i = '0;
    logic             wr_valid_i = 1'b0;
    logic             wr_ready_o;
    tl_stream_t       rd_pkt_o;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [CNT_W-1:0] pkt_cnt_o;
    logic [CNT_W-1:0] occupancy_o;
`ifdef TL_TX_PKT_FIFO_STATS_EN
    logic [CNT_W-1:0] hwm_o;
    logic [15:0]      drop_cnt_o;
`endif
    logic             err_oversize_o;
    logic             err_framing_o;

    always #5 clk = ~clk;

    tl_tx_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_pkt_i       (wr_pkt_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .rd_pkt_o       (rd_pkt_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .pkt_cnt_o      (pkt_cnt_o),
        .occupancy_o    (occupancy_o),
`ifdef TL_TX_PKT_FIFO_STATS_EN
        .hwm_o          (hwm_o),
        .drop_cnt_o     (drop_cnt_o),
`endif
        .err_oversize_o (err_oversize_o),
        .err_framing_o  (err_framing_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stored contents are a queue of beats in read order.
    tl_stream_t stim[$];
    tl_stream_t sb[$];
    int         m_pkts  = 0;
    int         m_start = 0;
    int         m_mode  = 0;
    bit         m_ov    = 1'b0;
    bit         m_fr    = 1'b0;
    bit         mon_en  = 1'b0;
    bit         m_roll, m_wr, m_rd;
    tl_stream_t m_b;

    function automatic bit m_ready();
        return (sb.size() < DEPTH) || (m_mode == 2);
    endfunction

    // advance the model on each clock edge from the driven inputs
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            stim.delete();
            m_pkts = 0; m_start = 0; m_mode = 0; m_ov = 1'b0; m_fr = 1'b0;
        end else begin
            m_roll = (m_mode == 1) && (sb.size() == DEPTH) && (m_pkts == 0);
            m_wr   = wr_valid_i && m_ready();
            m_rd   = (m_pkts != 0) && rd_ready_i;
            if (m_rd) begin
                m_b = sb.pop_front();
                if (m_b.eop) m_pkts--;
                if (m_start > 0) m_start--;
            end
            if (m_wr) begin
                m_b = stim.pop_front();
                if (m_mode == 2) begin
                    if (wr_pkt_i.eop) m_mode = 0;
                end else begin
                    if ((m_mode == 0 && !wr_pkt_i.sop) || (m_mode == 1 && wr_pkt_i.sop)) m_fr = 1'b1;
                    if (m_mode == 0 || wr_pkt_i.sop) m_start = sb.size();
                    sb.push_back(wr_pkt_i);
                    if (wr_pkt_i.eop) begin
                        m_pkts++;
                        m_mode = 0;
                    end else m_mode = 1;
                end
            end
            if (m_roll) begin
                while (sb.size() > m_start) m_b = sb.pop_back();
                m_mode = 2;
                m_ov = 1'b1;
            end
        end
    end

    // monitor: compare status every cycle and the head beat on every pop
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("wr_ready", 64'(wr_ready_o), 64'(m_ready()));
            chk("rd_valid", 64'(rd_valid_o), 64'(m_pkts != 0));
            chk("occupancy", 64'(occupancy_o), 64'(sb.size()));
            chk("pkt_cnt", 64'(pkt_cnt_o), 64'(m_pkts));
            chk("err_oversize", 64'(err_oversize_o), 64'(m_ov));
            chk("err_framing", 64'(err_framing_o), 64'(m_fr));
            if (sb.size() == 0) chk("rd_pkt_empty", 64'(rd_pkt_o), 64'(0));
            else if (m_pkts != 0 && rd_ready_i) chk("rd_pkt", 64'(rd_pkt_o), 64'(sb[0]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic add_pkt(input int len, input int sop_at);
        tl_stream_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.sop  = (i == 0) || (i == sop_at);
            b.eop  = (i == len - 1);
            stim.push_back(b);
        end
    endtask

    task automatic set_rd(input int rmode);
        rd_ready_i = (rmode == 2) ? 1'($urandom_range(1)) : (rmode == 1);
    endtask

    task automatic send(input int rmode, input bit rvalid, input int budget);
        int n = 0;
        while (stim.size() > 0 && n < budget) begin
            wr_valid_i = !rvalid || ($urandom_range(3) != 0);
            wr_pkt_i   = stim[0];
            set_rd(rmode);
            step();
            n++;
        end
        wr_valid_i = 1'b0;
        chk("send_done", 64'(stim.size()), 64'(0));
    endtask

    task automatic drain(input int rmode, input int budget);
        int n = 0;
        wr_valid_i = 1'b0;
        while (m_pkts != 0 && n < budget) begin
            set_rd(rmode);
            step();
            n++;
        end
        rd_ready_i = 1'b0;
        chk("drain_done", 64'(m_pkts), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_stream_t b;
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_wr_ready", 64'(wr_ready_o), 64'(1));
        chk("rst_rd_valid", 64'(rd_valid_o), 64'(0));
        chk("rst_occ", 64'(occupancy_o), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'(0));
        chk("rst_rd_pkt", 64'(rd_pkt_o), 64'(0));

        b = '{data: 32'hA5, sop: 1'b1, eop: 1'b1};
        stim.push_back(b);
        wr_pkt_i = b;
        wr_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
        chk("single_rd_valid", 64'(rd_valid_o), 64'(1));
        chk("single_pkt_cnt", 64'(pkt_cnt_o), 64'(1));
        chk("single_occ", 64'(occupancy_o), 64'(1));
        chk("single_data", 64'(rd_pkt_o.data), 64'h0A5);
        drain(1, 10);
        chk("single_after_occ", 64'(occupancy_o), 64'(0));

        add_pkt(3, -1);
        send(1, 1'b0, 20);
        drain(1, 20);

        for (int i = 0; i < 4; i++) add_pkt(4, -1);
        send(0, 1'b0, 40);
        chk("full_occ", 64'(occupancy_o), 64'(16));
        chk("full_wr_ready", 64'(wr_ready_o), 64'(0));
        chk("full_pkt_cnt", 64'(pkt_cnt_o), 64'(4));
        add_pkt(1, -1);
        send(1, 1'b0, 20);
        drain(1, 40);

        add_pkt(20, -1);
        send(1, 1'b0, 60);
        chk("ovs_flag", 64'(err_oversize_o), 64'(1));
        chk("ovs_occ", 64'(occupancy_o), 64'(0));
        chk("ovs_pkt_cnt", 64'(pkt_cnt_o), 64'(0));
        add_pkt(2, -1);
        send(1, 1'b0, 20);
        drain(1, 20);

        add_pkt(5, 2);
        send(0, 1'b0, 20);
        chk("frm_flag", 64'(err_framing_o), 64'(1));
        chk("frm_pkt_cnt", 64'(pkt_cnt_o), 64'(1));
        b = '{data: 32'h5A5A, sop: 1'b0, eop: 1'b1};
        stim.push_back(b);
        send(0, 1'b0, 10);
        chk("frm_orphan_cnt", 64'(pkt_cnt_o), 64'(2));
        drain(1, 30);
        chk("frm_sticky", 64'(err_framing_o), 64'(1));

        for (int p = 0; p < 200; p++) begin
            add_pkt(($urandom_range(19) == 0) ? 32'($urandom_range(20, 17)) : 32'($urandom_range(8, 1)), -1);
            send(2, 1'b1, 400);
        end
        drain(2, 1000);

        add_pkt(3, -1);
        add_pkt(3, -1);
        send(0, 1'b0, 20);
        add_pkt(5, -1);
        wr_valid_i = 1'b1;
        wr_pkt_i = stim[0];
        step();
        wr_pkt_i = stim[0];
        step();
        wr_valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_occ", 64'(occupancy_o), 64'(0));
        chk("mrst_rd_valid", 64'(rd_valid_o), 64'(0));
        chk("mrst_wr_ready", 64'(wr_ready_o), 64'(1));
        chk("mrst_err_ov", 64'(err_oversize_o), 64'(0));
        chk("mrst_err_fr", 64'(err_framing_o), 64'(0));
        chk("mrst_pkt_cnt", 64'(pkt_cnt_o), 64'(0));
        add_pkt(2, -1);
        send(1, 1'b0, 20);
        drain(1, 20);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
